// File: rtl/bcd_alu_seq.sv
// Digit-serial sign-magnitude BCD adder/subtractor, one digit per clock, LSD first.
// Optional build macro BCD_ALU_SAT_EN: saturate the magnitude to all 9s on overflow.
module bcd_alu_seq #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic                    start,
    input  logic [2:0]              opcode,
    input  logic [4*NUM_DIGITS:0]   op1,
    input  logic [4*NUM_DIGITS:0]   op2,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS:0]   result,
    output logic                    o_flag,
    output logic                    sign
);

    localparam int MW = 4 * NUM_DIGITS;
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);
    localparam logic [MW-1:0] SAT_MAG = {NUM_DIGITS{4'd9}};
`ifdef BCD_ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_COMP,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            carry_reg, carry_next;
    logic [MW-1:0]   a_reg, a_next;
    logic [MW-1:0]   b_reg, b_next;
    logic [MW-1:0]   mag_reg, mag_next;
    logic            sa_reg, sa_next;
    logic            sb_reg, sb_next;
    logic [MW:0]     result_reg, result_next;
    logic            o_flag_reg, o_flag_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;

    logic [3:0]      a_dig [NUM_DIGITS];
    logic [3:0]      b_dig [NUM_DIGITS];
    logic [3:0]      m_dig [NUM_DIGITS];
    logic [MW-1:0]   mag_upd;
    logic [3:0]      x_dig, y_dig, sum_digit;
    logic [4:0]      dsum;
    logic            sum_carry;
    logic            same_sign;
    logic            mag_zero;
    logic            eff_sign2;

    assign same_sign = (sa_reg == sb_reg);
    assign eff_sign2 = op2[MW] ^ (opcode == 3'b010);

    // Digit views of the operands and the partial magnitude; mag_upd is the
    // partial magnitude with the digit being produced this cycle already merged in.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
            assign a_dig[gi] = a_reg[4*gi +: 4];
            assign b_dig[gi] = b_reg[4*gi +: 4];
            assign m_dig[gi] = mag_reg[4*gi +: 4];
            assign mag_upd[4*gi +: 4] = (cnt_reg == CW'(gi)) ? sum_digit : mag_reg[4*gi +: 4];
        end
    endgenerate

    assign mag_zero = (mag_upd == '0);

    // Shared digit adder: operand add in ADD, 10's complement in COMP.
    always_comb begin
        x_dig = a_dig[cnt_reg];
        y_dig = same_sign ? b_dig[cnt_reg] : (4'd9 - b_dig[cnt_reg]);
        if (state_reg == S_COMP) begin
            x_dig = 4'd9 - m_dig[cnt_reg];
            y_dig = 4'd0;
        end
        dsum = {1'b0, x_dig} + {1'b0, y_dig} + {4'd0, carry_reg};
        if (dsum > 5'd9) begin
            sum_digit = dsum[3:0] + 4'd6;
            sum_carry = 1'b1;
        end else begin
            sum_digit = dsum[3:0];
            sum_carry = 1'b0;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        carry_next  = carry_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        mag_next    = mag_reg;
        sa_next     = sa_reg;
        sb_next     = sb_reg;
        result_next = result_reg;
        o_flag_next = o_flag_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ADD;
                    a_next     = op1[MW-1:0];
                    b_next     = op2[MW-1:0];
                    sa_next    = op1[MW];
                    sb_next    = eff_sign2;
                    // Differing signs add the 9's complement, so seed the +1 here.
                    carry_next = (op1[MW] != eff_sign2);
                    cnt_next   = '0;
                    mag_next   = '0;
                end
            end

            S_ADD: begin
                mag_next   = mag_upd;
                carry_next = sum_carry;
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == LAST_DIGIT) begin
                    cnt_next = '0;
                    if (same_sign) begin
                        state_next  = S_DONE;
                        o_flag_next = sum_carry;
                        if (sum_carry && SAT_EN) begin
                            result_next = {sa_reg, SAT_MAG};
                        end else begin
                            result_next = {sa_reg & ~mag_zero, mag_upd};
                        end
                    end else if (sum_carry) begin
                        state_next  = S_DONE;
                        o_flag_next = 1'b0;
                        result_next = {sa_reg & ~mag_zero, mag_upd};
                    end else begin
                        // |A| < |B|: the partial result is a 10's complement.
                        state_next = S_COMP;
                        carry_next = 1'b1;
                    end
                end
            end

            S_COMP: begin
                mag_next   = mag_upd;
                carry_next = sum_carry;
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == LAST_DIGIT) begin
                    cnt_next    = '0;
                    state_next  = S_DONE;
                    o_flag_next = 1'b0;
                    result_next = {sb_reg & ~mag_zero, mag_upd};
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next == S_ADD) || (state_next == S_COMP);
        done_next = (state_next == S_DONE);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            carry_reg  <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            mag_reg    <= '0;
            sa_reg     <= 1'b0;
            sb_reg     <= 1'b0;
            result_reg <= '0;
            o_flag_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            carry_reg  <= carry_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            mag_reg    <= mag_next;
            sa_reg     <= sa_next;
            sb_reg     <= sb_next;
            result_reg <= result_next;
            o_flag_reg <= o_flag_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign o_flag = o_flag_reg;
    assign sign   = result_reg[MW];

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Scoreboard bench for bcd_alu_seq: stimulus pushes integer-model expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_bcd_alu_seq;

    localparam int N = 4;
    localparam int W = 4 * N + 1;
    localparam longint P10 = 10000;
`ifdef BCD_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         nRst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   opcode = 3'b000;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic         busy, done, o_flag, sign;
    logic [W-1:0] result;

    bcd_alu_seq #(.NUM_DIGITS(N)) dut (
        .clk    (clk),
        .nRst   (nRst),
        .start  (start),
        .opcode (opcode),
        .op1    (op1),
        .op2    (op2),
        .busy   (busy),
        .done   (done),
        .result (result),
        .o_flag (o_flag),
        .sign   (sign)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         ofl;
        int           dcyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    function automatic longint bcd2int(input logic [W-1:0] v);
        longint r = 0;
        for (int i = N - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-2:0] int2bcd(input longint x);
        logic [W-2:0] r;
        longint t = x;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] mk(input logic s, input longint m);
        return {s, int2bcd(m)};
    endfunction

    // Reference: signed integer arithmetic on the decoded magnitudes.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] opc, input int t0);
        exp_t   e;
        logic   sa = a[W-1];
        logic   sb = b[W-1] ^ (opc == 3'b010);
        longint ma = bcd2int(a);
        longint mb = bcd2int(b);
        longint mag;
        logic   s;
        logic   ov = 1'b0;
        int     lat = N;
        if (sa == sb) begin
            mag = ma + mb;
            s = sa;
            if (mag >= P10) begin
                ov = 1'b1;
                mag = SAT ? (P10 - 1) : (mag - P10);
            end
        end else if (ma >= mb) begin
            mag = ma - mb;
            s = sa;
        end else begin
            mag = mb - ma;
            s = sb;
            lat = 2 * N;
        end
        if (mag == 0) s = 1'b0;
        e.res  = {s, int2bcd(mag)};
        e.ofl  = ov;
        e.dcyc = t0 + lat;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Waits for IDLE, presents operands, records the accept edge and expectation.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] opc,
                        input bit hold, output int t0, output int dc);
        int   w = 0;
        exp_t e;
        @(negedge clk);
        op1 = a;
        op2 = b;
        opcode = opc;
        start = 1'b1;
        while ((busy || done) && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got busy=%0b done=%0b required idle", busy, done);
        end
        t0 = cyc + 1;
        e = model(a, b, opc, t0);
        dc = e.dcyc;
        q.push_back(e);
        $display("issue op1=%h op2=%h opc=%b accept_edge=%0d exp=%h ofl=%0b", a, b, opc, t0, e.res, e.ofl);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    always @(negedge clk) begin
        if (nRst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with result %h required no done (cycle %0d)", result, cyc);
            end else begin
                mon_e = q.pop_front();
                $display("done result=%h o_flag=%0b sign=%0b cycle=%0d", result, o_flag, sign, cyc);
                check("result", 32'(result), 32'(mon_e.res));
                check("o_flag", 32'(o_flag), 32'(mon_e.ofl));
                check("sign", 32'(sign), 32'(mon_e.res[W-1]));
                check("done_cycle", 32'(cyc), 32'(mon_e.dcyc));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        int t0, dc, prev_dc, w;
        logic [W-1:0] ra, rb;
        logic [2:0] ro;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_o_flag", 32'(o_flag), 32'd0);
        check("rst_sign", 32'(sign), 32'd0);
        nRst = 1'b1;

        send(mk(0, 123), mk(0, 456), 3'b000, 0, t0, dc);
        send(mk(0, 250), mk(0, 700), 3'b010, 0, t0, dc);
        send(mk(0, 9999), mk(0, 1), 3'b000, 0, t0, dc);
        send(mk(1, 5), mk(1, 5), 3'b010, 0, t0, dc);
        send(mk(1, 300), mk(0, 200), 3'b000, 0, t0, dc);

        // Start pulse while busy must be ignored.
        send(mk(0, 4321), mk(0, 1234), 3'b000, 0, t0, dc);
        repeat (2) @(negedge clk);
        op1 = mk(1, 7777);
        op2 = mk(0, 42);
        opcode = 3'b010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Abort two cycles into an operation.
        send(mk(0, 111), mk(0, 222), 3'b000, 0, t0, dc);
        @(negedge clk);
        @(negedge clk);
        nRst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_o_flag", 32'(o_flag), 32'd0);
        check("abort_sign", 32'(sign), 32'd0);
        void'(q.pop_back());
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        repeat (12) @(negedge clk);

        send(mk(0, 1111), mk(1, 2222), 3'b000, 0, t0, dc);

        // Back-to-back with start held high.
        send(mk(0, 8000), mk(0, 2500), 3'b000, 1, t0, dc);
        prev_dc = dc;
        send(mk(1, 10), mk(1, 990), 3'b000, 1, t0, dc);
        check("b2b_accept_1", 32'(t0), 32'(prev_dc + 2));
        prev_dc = dc;
        send(mk(0, 5), mk(0, 6006), 3'b010, 1, t0, dc);
        check("b2b_accept_2", 32'(t0), 32'(prev_dc + 2));
        @(negedge clk);
        start = 1'b0;

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                ra = mk(1'($urandom_range(0, 1)), longint'($urandom_range(5000, 9999)));
                rb = mk(1'($urandom_range(0, 1)), longint'($urandom_range(5000, 9999)));
            end else begin
                ra = mk(1'($urandom_range(0, 1)), longint'($urandom_range(0, 9999)));
                rb = mk(1'($urandom_range(0, 1)), longint'($urandom_range(0, 9999)));
            end
            ro = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'($urandom_range(0, 7));
            send(ra, rb, ro, 0, t0, dc);
        end

        w = 0;
        while (q.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending required 0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
